// File: rtl/lsu_issue_buffer.sv
// In-order issue buffer between the LSU reservation station and the load/store pipeline.
// Handshake: an entry moves to the LSU on a rising edge where lsu_valid && lsu_ready && !flush.
module lsu_issue_buffer #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 32,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] issue_instruction_ls,
    input  logic               issue_ls_valid,
    output logic               busy_lsu,
    output logic [ENTRY_W-1:0] lsu_instruction,
    output logic               lsu_valid,
    input  logic               lsu_ready,
    output logic               overflow_err,
    output logic [PTR_W:0]     occupancy
);

    localparam logic [PTR_W:0] C_DEPTH   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] C_BUSY_TH = (PTR_W+1)'(DEPTH - 1);

    logic [ENTRY_W-1:0] r_entry [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_overflow;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full = (r_count == C_DEPTH);
    assign w_push = issue_ls_valid && !flush && !w_full;
    assign w_pop  = lsu_valid && lsu_ready && !flush;

    assign lsu_valid       = (r_count != '0);
    assign lsu_instruction = r_entry[r_rd_ptr];
    // Threshold at DEPTH-1 leaves room for the issue already in flight when busy rises.
    assign busy_lsu        = (r_count >= C_BUSY_TH);
    assign overflow_err    = r_overflow;
    assign occupancy       = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entry[r_wr_ptr] <= issue_instruction_ls;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky until reset; a flush does not hide that an issue was lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (issue_ls_valid && !flush && w_full) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lsu_issue_buffer.sv
// Self-checking bench for lsu_issue_buffer: scenario tasks plus a scoreboard on the LSU side.
module tb_lsu_issue_buffer;

  localparam int DEPTH = 4;
  localparam int EW    = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [EW-1:0] issue_instruction_ls;
  logic          issue_ls_valid;
  logic          busy_lsu;
  logic [EW-1:0] lsu_instruction;
  logic          lsu_valid;
  logic          lsu_ready;
  logic          overflow_err;
  logic [2:0]    occupancy;

  int total = 0;
  int bad   = 0;
  int m_cnt = 0;
  logic [EW-1:0] exp_q[$];

  lsu_issue_buffer #(.DEPTH(DEPTH), .ENTRY_W(EW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .issue_instruction_ls (issue_instruction_ls),
    .issue_ls_valid       (issue_ls_valid),
    .busy_lsu             (busy_lsu),
    .lsu_instruction      (lsu_instruction),
    .lsu_valid            (lsu_valid),
    .lsu_ready            (lsu_ready),
    .overflow_err         (overflow_err),
    .occupancy            (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // scoreboard: every accepted LSU handshake must match the oldest accepted issue
  always @(negedge clk) begin
    if (rst && !flush && lsu_valid && lsu_ready) begin
      logic [EW-1:0] exp;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_order: got %h, expected no entry (queue empty)", lsu_instruction);
      end else begin
        exp = exp_q.pop_front();
        if (lsu_instruction !== exp) begin
          bad++;
          $display("FAIL pop_order: got %h, expected %h", lsu_instruction, exp);
        end
      end
    end
  end

  function automatic logic [EW-1:0] mk(input int id);
    logic [EW-1:0] d;
    d = {26'($urandom_range(0, 32'h3ff_ffff)), 6'(id)};
    return d;
  endfunction

  // driver: called at posedge+1, applies inputs for one edge, updates the reference model
  task automatic drive(input logic v, input logic [EW-1:0] d, input logic rdy, input logic fl);
    bit p;
    bit q;
    issue_ls_valid       = v;
    issue_instruction_ls = d;
    lsu_ready            = rdy;
    flush                = fl;
    p = v && !fl && (m_cnt < DEPTH);
    q = (m_cnt != 0) && rdy && !fl;
    if (fl) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (p) exp_q.push_back(d);
      m_cnt = m_cnt + int'(p) - int'(q);
    end
    @(posedge clk);
    #1;
    issue_ls_valid = 1'b0;
    lsu_ready      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    issue_ls_valid = 1'b0;
    issue_instruction_ls = '0;
    lsu_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (occupancy !== 3'd0 || busy_lsu !== 1'b0 || lsu_valid !== 1'b0 || overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: occ=%0d busy=%b valid=%b ovf=%b, expected 0 0 0 0",
               occupancy, busy_lsu, lsu_valid, overflow_err);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    logic [5:0] head_id;
    for (int i = 1; i <= 3; i++) drive(1'b1, mk(i), 1'b0, 1'b0);
    head_id = lsu_instruction[5:0];
    total++;
    if (occupancy !== 3'd3 || busy_lsu !== 1'b1 || lsu_valid !== 1'b1 || head_id !== 6'd1) begin
      bad++;
      $display("FAIL fill3: occ=%0d busy=%b valid=%b head=%0d, expected 3 1 1 1",
               occupancy, busy_lsu, lsu_valid, head_id);
    end
  endtask

  task automatic test_drain();
    logic exp_busy;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      exp_busy = 1'b0;
      total++;
      if (occupancy !== 3'(2 - i) || busy_lsu !== exp_busy || lsu_valid !== (i != 2)) begin
        bad++;
        $display("FAIL drain_%0d: occ=%0d busy=%b valid=%b, expected %0d 0 %b",
                 i, occupancy, busy_lsu, lsu_valid, 2 - i, (i != 2));
      end
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, mk(4), 1'b0, 1'b0);
    drive(1'b1, mk(5), 1'b0, 1'b0);
    drive(1'b1, mk(6), 1'b0, 1'b0);
    drive(1'b1, mk(8), 1'b0, 1'b0);
    total++;
    if (occupancy !== 3'd4 || busy_lsu !== 1'b1 || overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL full4: occ=%0d busy=%b ovf=%b, expected 4 1 0", occupancy, busy_lsu, overflow_err);
    end
    drive(1'b1, mk(9), 1'b0, 1'b0);
    total++;
    if (occupancy !== 3'd4 || overflow_err !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: occ=%0d ovf=%b, expected 4 1", occupancy, overflow_err);
    end
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, mk(10), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (overflow_err !== 1'b1 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL overflow_sticky: ovf=%b occ=%0d, expected 1 0", overflow_err, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    for (int i = 0; i < 3; i++) drive(1'b1, mk(11 + i), 1'b0, 1'b0);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, mk(i == 0 ? 7 : 20 + i), 1'b1, 1'b0);
      total++;
      if (occupancy !== 3'd3 || busy_lsu !== 1'b1) begin
        bad++;
        $display("FAIL push_pop_%0d: occ=%0d busy=%b, expected 3 1", i, occupancy, busy_lsu);
      end
    end
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (lsu_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL b2b_empty: valid=%b occ=%0d, expected 0 0", lsu_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, mk(30), 1'b0, 1'b0);
    drive(1'b1, mk(31), 1'b0, 1'b0);
    drive(1'b1, mk(32), 1'b1, 1'b1);
    total++;
    if (occupancy !== 3'd0 || lsu_valid !== 1'b0 || busy_lsu !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear: occ=%0d valid=%b busy=%b, expected 0 0 0", occupancy, lsu_valid, busy_lsu);
    end
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, mk(33), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (occupancy !== 3'd0) begin
      bad++;
      $display("FAIL flush_after: occ=%0d, expected 0", occupancy);
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] head_id;
    for (int i = 0; i < 3; i++) drive(1'b1, mk(40 + i), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (occupancy !== 3'd0 || lsu_valid !== 1'b0 || busy_lsu !== 1'b0 || overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: occ=%0d valid=%b busy=%b ovf=%b, expected 0 0 0 0",
               occupancy, lsu_valid, busy_lsu, overflow_err);
    end
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, mk(5), 1'b0, 1'b0);
    head_id = lsu_instruction[5:0];
    total++;
    if (lsu_valid !== 1'b1 || head_id !== 6'd5 || occupancy !== 3'd1) begin
      bad++;
      $display("FAIL after_reset: valid=%b head=%0d occ=%0d, expected 1 5 1", lsu_valid, head_id, occupancy);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expected entries never output, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_issue_buffer.md
Name: lsu_issue_buffer

Overview:
- Receives one issued load/store per cycle from the LSU reservation station (`issue_instruction_ls` / `issue_ls_valid`).
- Holds entries in a small in-order FIFO and presents them to the load/store execution pipeline over a valid/ready handshake.
- Drives `busy_lsu` back to dispatch/issue so the reservation station stops issuing before the buffer overflows.
- Flush clears all buffered entries.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  pipeline flush; discards all buffered entries.
- issue_instruction_ls  input  $bits(RS_ENTRY_t)  issued load/store entry from the reservation station.
- issue_ls_valid  input  1  `issue_instruction_ls` is valid this cycle.
- busy_lsu  output  1  back-pressure to the reservation station; high means do not issue.
- lsu_instruction  output  $bits(RS_ENTRY_t)  head entry presented to the LSU pipeline.
- lsu_valid  output  1  `lsu_instruction` is valid.
- lsu_ready  input  1  LSU accepts the head entry this cycle.
- overflow_err  output  1  sticky error: an issue arrived while the buffer was full.
- occupancy  output  PTR_W+1  current entry count, for debug/perf.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr and count are 0.
  - busy_lsu=0, lsu_valid=0, overflow_err=0, occupancy=0.
  - Entry storage is not reset; lsu_instruction is don't-care while lsu_valid=0.
- Storage: circular array of DEPTH `RS_ENTRY_t` entries.
  - Pointers wrap modulo DEPTH, from DEPTH-1 to 0.
  - count is PTR_W+1 bits wide, range 0..DEPTH.
- Push: `push = issue_ls_valid && !flush && (count < DEPTH)`.
  - Writes entry[wr_ptr] and increments wr_ptr at the clock edge.
- Pop: `pop = lsu_valid && lsu_ready && !flush`.
  - Increments rd_ptr.
- Outputs:
  - lsu_valid = (count != 0), combinational from registered count.
  - lsu_instruction = entry[rd_ptr], combinational read.
  - No bypass: an entry pushed in cycle N is visible to the LSU no earlier than cycle N+1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - Simultaneous push+pop is legal at count=DEPTH-1 and at count=1. At count=0, pop cannot occur.
- busy_lsu = (count >= DEPTH-1), combinational from registered count.
  - Gives one cycle of slack: issue is sampled in the same cycle busy is evaluated, so an issue accepted at count=DEPTH-2 fills to DEPTH-1 and busy rises the next cycle.
  - busy does not consider a same-cycle pop (conservative).
- Full case (count == DEPTH with issue_ls_valid=1):
  - Entry is dropped; no pointer or count change.
  - overflow_err sets to 1 at the clock edge and stays 1 until reset (flush does not clear it).
- Flush (synchronous, highest priority):
  - At the edge with flush=1, wr_ptr, rd_ptr and count go to 0.
  - Any same-cycle push or pop is ignored.
  - lsu_valid=0 from the next cycle; busy_lsu=0 from the next cycle.
- occupancy = count.
- Ordering: entries leave in exactly the order accepted; no reordering or bypass.
- Reset asserted mid-operation: all state returns immediately to reset values regardless of clk.

Test Plan:
- Reset, then 3 issues (ROB ids 1, 2, 3) in consecutive cycles with lsu_ready=0 → occupancy=3, busy_lsu=1 after the 3rd edge (DEPTH=4), lsu_valid=1, lsu_instruction.rob_id=1.
- Continue from 3 entries, lsu_ready=1 for 3 cycles, no issue → pops ROB ids 1, 2, 3 in order, busy_lsu drops when occupancy=2, lsu_valid=0 after the 3rd pop.
- Fill to 4 by issuing while ignoring busy, then issue ROB id 9 at full → entry 9 never appears at the output, overflow_err=1 and stays 1 after a later flush.
- count=3 with issue (id 7) and lsu_ready=1 in the same cycle → occupancy stays 3, head advances, id 7 is output after the older entries; repeat 10 cycles to cover pointer wrap with correct ordering.
- count=2, flush=1 coinciding with issue_ls_valid=1 and lsu_ready=1 → next cycle occupancy=0, lsu_valid=0, busy_lsu=0, issued entry never output.
- Drop rst asynchronously between clock edges with 3 entries held → outputs go to reset values before the next clk edge; after release the first issue (id 5) appears at the head.
